// File: rtl/lock_pkg.sv
// Shared types and default timing for the canal lock sequencer.
// State encoding is visible on the debug/LED output, so the values are fixed.
package lock_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        EQ1    = 4'd1,
        OPEN1  = 4'd2,
        ENTER  = 4'd3,
        CLOSE1 = 4'd4,
        EQ2    = 4'd5,
        OPEN2  = 4'd6,
        EXIT   = 4'd7,
        CLOSE2 = 4'd8
    } state_t;

    typedef enum logic {
        SIDE_OUTER = 1'b0,
        SIDE_INNER = 1'b1
    } side_t;

    localparam int DEF_LEVEL_W       = 32'sd8;
    localparam int DEF_FILL_DIV      = 32'sd4;
    localparam int DEF_GATE_CYCLES   = 32'sd3;
    localparam int DEF_ENTER_TIMEOUT = 32'sd16;
    localparam int DEF_LOCK_INIT     = 32'sd0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    function automatic side_t other_side(input side_t s);
        return (s == SIDE_OUTER) ? SIDE_INNER : SIDE_OUTER;
    endfunction

endpackage

// File: rtl/lock_level_stepper.sv
// Chamber water level: steps one unit toward the target every FILL_DIV enabled
// cycles and reports the valve demand and equality with the target.
module lock_level_stepper
    import lock_pkg::*;
#(
    parameter int LEVEL_W   = DEF_LEVEL_W,
    parameter int FILL_DIV  = DEF_FILL_DIV,
    parameter int LOCK_INIT = DEF_LOCK_INIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_enable,
    input  logic               i_hold,
    input  logic [LEVEL_W-1:0] i_target,
    output logic [LEVEL_W-1:0] o_lock_level,
    output logic               o_fill_valve,
    output logic               o_drain_valve,
    output logic               o_at_target
);

    localparam int               DIV_W    = cnt_w(FILL_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FILL_DIV - 1);

    logic [LEVEL_W-1:0] r_level;
    logic [DIV_W-1:0]   r_div;
    logic               w_below;
    logic               w_above;
    logic               w_moving;
    logic               w_terminal;

    // Direction decode against the registered level; valves follow it directly.
    always_comb begin
        w_below    = (r_level < i_target);
        w_above    = (r_level > i_target);
        w_moving   = i_enable & ~i_hold & (w_below | w_above);
        w_terminal = w_moving & (r_div == DIV_LAST);
    end

    // Step divider and level register; hold freezes both.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= LEVEL_W'(LOCK_INIT);
            r_div   <= '0;
        end else if (i_hold) begin
            r_level <= r_level;
            r_div   <= r_div;
        end else if (!w_moving) begin
            r_div   <= '0;
        end else if (w_terminal) begin
            r_div   <= '0;
            r_level <= w_below ? (r_level + LEVEL_W'(1'b1)) : (r_level - LEVEL_W'(1'b1));
        end else begin
            r_div   <= r_div + DIV_W'(1'b1);
        end
    end

    assign o_lock_level  = r_level;
    assign o_fill_valve  = i_enable & ~i_hold & w_below;
    assign o_drain_valve = i_enable & ~i_hold & w_above;
    assign o_at_target   = ~(w_below | w_above);

endmodule

// File: rtl/lock_sequencer.sv
// One gondola transit through the canal lock: side arbitration, equalisation,
// gate sequencing with entry timeout, and the debug state output.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int LEVEL_W       = DEF_LEVEL_W,
    parameter int FILL_DIV      = DEF_FILL_DIV,
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int ENTER_TIMEOUT = DEF_ENTER_TIMEOUT,
    parameter int LOCK_INIT     = DEF_LOCK_INIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_outer,
    input  logic               req_inner,
    input  logic               gondola_in,
    input  logic               gondola_out,
    input  logic               hold,
    input  logic [LEVEL_W-1:0] outer_level,
    input  logic [LEVEL_W-1:0] inner_level,
    output logic [LEVEL_W-1:0] lock_level,
    output logic               outer_gate_open,
    output logic               inner_gate_open,
    output logic               fill_valve,
    output logic               drain_valve,
    output logic               busy,
    output logic               serving_inner,
    output logic               aborted,
    output logic [3:0]         state
);

    localparam int            GW        = cnt_w(GATE_CYCLES);
    localparam int            TW        = cnt_w(ENTER_TIMEOUT);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ENTER_TIMEOUT - 1);

    state_t             r_state;
    side_t              r_last_served;
    side_t              r_serving;
    logic [LEVEL_W-1:0] r_target;
    logic [GW-1:0]      r_gcnt;
    logic [TW-1:0]      r_tcnt;
    logic               r_pend_outer;
    logic               r_pend_inner;
    logic               r_abort_txn;
    logic               r_aborted;
    logic               r_outer_gate;
    logic               r_inner_gate;
    logic               r_busy;

    logic               w_any_pend;
    side_t              w_pick;
    logic               w_leave_idle;
    logic [LEVEL_W-1:0] w_entry_level;
    logic [LEVEL_W-1:0] w_exit_level;
    logic               w_eq_active;
    logic               w_at_target;

    // Round-robin pick; a lone request always wins regardless of history.
    always_comb begin
        w_any_pend = r_pend_outer | r_pend_inner;
        if (r_pend_outer && r_pend_inner) begin
            w_pick = other_side(r_last_served);
        end else if (r_pend_inner) begin
            w_pick = SIDE_INNER;
        end else begin
            w_pick = SIDE_OUTER;
        end
        w_leave_idle  = (r_state == IDLE) & ~hold & w_any_pend;
        w_entry_level = (w_pick == SIDE_INNER) ? inner_level : outer_level;
        w_exit_level  = (r_serving == SIDE_INNER) ? outer_level : inner_level;
        w_eq_active   = (r_state == EQ1) || (r_state == EQ2);
    end

    // Pending capture runs even under hold; clearing the served side wins over a same-cycle request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_outer <= 1'b0;
            r_pend_inner <= 1'b0;
        end else begin
            r_pend_outer <= (w_leave_idle && (w_pick == SIDE_OUTER)) ? 1'b0 : (r_pend_outer | req_outer);
            r_pend_inner <= (w_leave_idle && (w_pick == SIDE_INNER)) ? 1'b0 : (r_pend_inner | req_inner);
        end
    end

    // Transit sequencing with registered gate commands, busy and abort pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_served <= SIDE_INNER;
            r_serving     <= SIDE_OUTER;
            r_target      <= LEVEL_W'(LOCK_INIT);
            r_gcnt        <= '0;
            r_tcnt        <= '0;
            r_abort_txn   <= 1'b0;
            r_aborted     <= 1'b0;
            r_outer_gate  <= 1'b0;
            r_inner_gate  <= 1'b0;
            r_busy        <= 1'b0;
        end else if (hold) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_pend) begin
                        r_state     <= EQ1;
                        r_serving   <= w_pick;
                        r_target    <= w_entry_level;
                        r_abort_txn <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                EQ1: begin
                    if (w_at_target) begin
                        r_state      <= OPEN1;
                        r_gcnt       <= '0;
                        r_outer_gate <= (r_serving == SIDE_OUTER);
                        r_inner_gate <= (r_serving == SIDE_INNER);
                    end
                end
                OPEN1: begin
                    if (r_gcnt == GATE_LAST) begin
                        r_state <= ENTER;
                        r_gcnt  <= '0;
                        r_tcnt  <= '0;
                    end else begin
                        r_gcnt <= r_gcnt + GW'(1'b1);
                    end
                end
                ENTER: begin
                    if (gondola_in) begin
                        r_state <= CLOSE1;
                        r_gcnt  <= '0;
                    end else if (r_tcnt == TO_LAST) begin
                        r_state     <= CLOSE1;
                        r_gcnt      <= '0;
                        r_aborted   <= 1'b1;
                        r_abort_txn <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1'b1);
                    end
                end
                CLOSE1: begin
                    if (r_gcnt == GATE_LAST) begin
                        r_gcnt       <= '0;
                        r_outer_gate <= 1'b0;
                        r_inner_gate <= 1'b0;
                        if (r_abort_txn) begin
                            r_state       <= IDLE;
                            r_busy        <= 1'b0;
                            r_last_served <= r_serving;
                        end else begin
                            r_state  <= EQ2;
                            r_target <= w_exit_level;
                        end
                    end else begin
                        r_gcnt <= r_gcnt + GW'(1'b1);
                    end
                end
                EQ2: begin
                    if (w_at_target) begin
                        r_state      <= OPEN2;
                        r_gcnt       <= '0;
                        r_outer_gate <= (r_serving == SIDE_INNER);
                        r_inner_gate <= (r_serving == SIDE_OUTER);
                    end
                end
                OPEN2: begin
                    if (r_gcnt == GATE_LAST) begin
                        r_state <= EXIT;
                        r_gcnt  <= '0;
                    end else begin
                        r_gcnt <= r_gcnt + GW'(1'b1);
                    end
                end
                EXIT: begin
                    if (gondola_out) begin
                        r_state <= CLOSE2;
                        r_gcnt  <= '0;
                    end
                end
                CLOSE2: begin
                    if (r_gcnt == GATE_LAST) begin
                        r_state       <= IDLE;
                        r_gcnt        <= '0;
                        r_outer_gate  <= 1'b0;
                        r_inner_gate  <= 1'b0;
                        r_busy        <= 1'b0;
                        r_last_served <= r_serving;
                    end else begin
                        r_gcnt <= r_gcnt + GW'(1'b1);
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_outer_gate <= 1'b0;
                    r_inner_gate <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    lock_level_stepper #(
        .LEVEL_W   (LEVEL_W),
        .FILL_DIV  (FILL_DIV),
        .LOCK_INIT (LOCK_INIT)
    ) u_stepper (
        .clk           (clk),
        .reset         (reset),
        .i_enable      (w_eq_active),
        .i_hold        (hold),
        .i_target      (r_target),
        .o_lock_level  (lock_level),
        .o_fill_valve  (fill_valve),
        .o_drain_valve (drain_valve),
        .o_at_target   (w_at_target)
    );

    assign outer_gate_open = r_outer_gate;
    assign inner_gate_open = r_inner_gate;
    assign busy            = r_busy;
    assign serving_inner   = (r_serving == SIDE_INNER);
    assign aborted         = r_aborted;
    assign state           = r_state;

endmodule
